// File: rtl/msrv32_reg_block_2.sv
// Pipeline register between the decode stage and the execute/write-back stage of the RV32I core.
// Latency: exactly one clk_in cycle from every input to its *_reg_out, with no combinational path.
// Backpressure: none; every field loads on every rising edge, and there is no stall or enable.
//
// Ports:
//   clk_in, reset_in          clock; asynchronous active-high reset that clears every output
//   rd_addr_in .. csr_op_in   decoded control fields, each registered unchanged
//   rs1_in, rs2_in, imm_in    operand values, registered unchanged
//   pc_in, pc_plus_4_in       current PC and PC+4, registered unchanged
//   iadder_out_in             target address; bit 0 is cleared when branch_taken_in is set
//   *_reg_out                 registered copies of the matching inputs
module msrv32_reg_block_2 (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [4:0]  rd_addr_in,
  input  logic [11:0] csr_addr_in,
  input  logic [31:0] rs1_in,
  input  logic [31:0] rs2_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc_plus_4_in,
  input  logic [3:0]  alu_opcode_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic        alu_src_in,
  input  logic        csr_wr_en_in,
  input  logic        rf_wr_en_in,
  input  logic [2:0]  wb_mux_sel_in,
  input  logic [2:0]  csr_op_in,
  input  logic [31:0] imm_in,
  input  logic [31:0] iadder_out_in,
  input  logic        branch_taken_in,
  output logic [4:0]  rd_addr_reg_out,
  output logic [11:0] csr_addr_reg_out,
  output logic [31:0] rs1_reg_out,
  output logic [31:0] rs2_reg_out,
  output logic [31:0] pc_reg_out,
  output logic [31:0] pc_plus_reg_out,
  output logic [3:0]  alu_opcode_reg_out,
  output logic [1:0]  load_size_reg_out,
  output logic        load_unsigned_reg_out,
  output logic        alu_src_reg_out,
  output logic        csr_wr_en_reg_out,
  output logic        rf_wr_en_reg_out,
  output logic [2:0]  wb_mux_sel_reg_out,
  output logic [2:0]  csr_op_reg_out,
  output logic [31:0] imm_reg_out,
  output logic [31:0] iadder_out_reg_out
);

  // Taken branch and jump targets must be halfword aligned, and JALR in particular
  // architecturally drops bit 0. The branch flag affects only the target address
  // and never flushes the other fields.
  logic [31:0] iadder_aligned;

  always_comb begin
    iadder_aligned = iadder_out_in;
    if (branch_taken_in) begin
      iadder_aligned = {iadder_out_in[31:1], 1'b0};
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      rd_addr_reg_out       <= 5'd0;
      csr_addr_reg_out      <= 12'd0;
      rs1_reg_out           <= 32'd0;
      rs2_reg_out           <= 32'd0;
      pc_reg_out            <= 32'd0;
      pc_plus_reg_out       <= 32'd0;
      alu_opcode_reg_out    <= 4'd0;
      load_size_reg_out     <= 2'd0;
      load_unsigned_reg_out <= 1'b0;
      alu_src_reg_out       <= 1'b0;
      csr_wr_en_reg_out     <= 1'b0;
      rf_wr_en_reg_out      <= 1'b0;
      wb_mux_sel_reg_out    <= 3'd0;
      csr_op_reg_out        <= 3'd0;
      imm_reg_out           <= 32'd0;
      iadder_out_reg_out    <= 32'd0;
    end else begin
      rd_addr_reg_out       <= rd_addr_in;
      csr_addr_reg_out      <= csr_addr_in;
      rs1_reg_out           <= rs1_in;
      rs2_reg_out           <= rs2_in;
      pc_reg_out            <= pc_in;
      pc_plus_reg_out       <= pc_plus_4_in;
      alu_opcode_reg_out    <= alu_opcode_in;
      load_size_reg_out     <= load_size_in;
      load_unsigned_reg_out <= load_unsigned_in;
      alu_src_reg_out       <= alu_src_in;
      csr_wr_en_reg_out     <= csr_wr_en_in;
      rf_wr_en_reg_out      <= rf_wr_en_in;
      wb_mux_sel_reg_out    <= wb_mux_sel_in;
      csr_op_reg_out        <= csr_op_in;
      imm_reg_out           <= imm_in;
      iadder_out_reg_out    <= iadder_aligned;
    end
  end

endmodule

// File: tb/tb_msrv32_reg_block_2.sv
// Directed bench for the decode-to-execute pipeline register.
// Inputs change on the falling edge, and outputs are sampled 1 time unit after the rising edge.
// There is no flow control, so every task just drives and then checks.
module tb_msrv32_reg_block_2;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [4:0]  rd_addr_in;
  logic [11:0] csr_addr_in;
  logic [31:0] rs1_in, rs2_in, pc_in, pc_plus_4_in;
  logic [3:0]  alu_opcode_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in, alu_src_in, csr_wr_en_in, rf_wr_en_in;
  logic [2:0]  wb_mux_sel_in, csr_op_in;
  logic [31:0] imm_in, iadder_out_in;
  logic        branch_taken_in;

  logic [4:0]  rd_addr_reg_out;
  logic [11:0] csr_addr_reg_out;
  logic [31:0] rs1_reg_out, rs2_reg_out, pc_reg_out, pc_plus_reg_out;
  logic [3:0]  alu_opcode_reg_out;
  logic [1:0]  load_size_reg_out;
  logic        load_unsigned_reg_out, alu_src_reg_out, csr_wr_en_reg_out, rf_wr_en_reg_out;
  logic [2:0]  wb_mux_sel_reg_out, csr_op_reg_out;
  logic [31:0] imm_reg_out, iadder_out_reg_out;

  int n_cmp = 0;
  int n_err = 0;

  // Every output concatenated, for whole-block zero checks (225 bits).
  logic [224:0] all_outs;
  assign all_outs = {rd_addr_reg_out, csr_addr_reg_out, rs1_reg_out, rs2_reg_out,
                     pc_reg_out, pc_plus_reg_out, alu_opcode_reg_out, load_size_reg_out,
                     load_unsigned_reg_out, alu_src_reg_out, csr_wr_en_reg_out,
                     rf_wr_en_reg_out, wb_mux_sel_reg_out, csr_op_reg_out,
                     imm_reg_out, iadder_out_reg_out};

  always #5 clk_in = ~clk_in;

  msrv32_reg_block_2 dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .rd_addr_in(rd_addr_in), .csr_addr_in(csr_addr_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .pc_in(pc_in), .pc_plus_4_in(pc_plus_4_in),
    .alu_opcode_in(alu_opcode_in), .load_size_in(load_size_in),
    .load_unsigned_in(load_unsigned_in), .alu_src_in(alu_src_in),
    .csr_wr_en_in(csr_wr_en_in), .rf_wr_en_in(rf_wr_en_in),
    .wb_mux_sel_in(wb_mux_sel_in), .csr_op_in(csr_op_in),
    .imm_in(imm_in), .iadder_out_in(iadder_out_in), .branch_taken_in(branch_taken_in),
    .rd_addr_reg_out(rd_addr_reg_out), .csr_addr_reg_out(csr_addr_reg_out),
    .rs1_reg_out(rs1_reg_out), .rs2_reg_out(rs2_reg_out), .pc_reg_out(pc_reg_out),
    .pc_plus_reg_out(pc_plus_reg_out), .alu_opcode_reg_out(alu_opcode_reg_out),
    .load_size_reg_out(load_size_reg_out), .load_unsigned_reg_out(load_unsigned_reg_out),
    .alu_src_reg_out(alu_src_reg_out), .csr_wr_en_reg_out(csr_wr_en_reg_out),
    .rf_wr_en_reg_out(rf_wr_en_reg_out), .wb_mux_sel_reg_out(wb_mux_sel_reg_out),
    .csr_op_reg_out(csr_op_reg_out), .imm_reg_out(imm_reg_out),
    .iadder_out_reg_out(iadder_out_reg_out)
  );

  task automatic clear_inputs();
    rd_addr_in = '0; csr_addr_in = '0; rs1_in = '0; rs2_in = '0; pc_in = '0;
    pc_plus_4_in = '0; alu_opcode_in = '0; load_size_in = '0; load_unsigned_in = 1'b0;
    alu_src_in = 1'b0; csr_wr_en_in = 1'b0; rf_wr_en_in = 1'b0; wb_mux_sel_in = '0;
    csr_op_in = '0; imm_in = '0; iadder_out_in = '0; branch_taken_in = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Reset at t=0 with inputs still X, then reset held across a clock edge with live inputs.
  task automatic test_reset();
    reset_in = 1'b1;
    #1;
    n_cmp++;
    if (all_outs !== '0) begin
      n_err++;
      $display("FAIL reset_t0: got %h required 0", all_outs);
    end
    @(negedge clk_in);
    clear_inputs();
    rs1_in = 32'hDEAD_BEEF; rd_addr_in = 5'd9; rf_wr_en_in = 1'b1; iadder_out_in = 32'h55;
    tick();
    n_cmp++;
    if (all_outs !== '0) begin
      n_err++;
      $display("FAIL reset_held: got %h required 0", all_outs);
    end
  endtask

  task automatic test_basic();
    @(negedge clk_in);
    clear_inputs();
    reset_in = 1'b0;
    rd_addr_in = 5'd1; csr_addr_in = 12'd2; rs1_in = 32'd3; rs2_in = 32'd4; pc_in = 32'd5;
    pc_plus_4_in = 32'd6; alu_opcode_in = 4'd7; imm_in = 32'd15; iadder_out_in = 32'd16;
    tick();
    n_cmp++; if (rd_addr_reg_out !== 5'd1) begin n_err++; $display("FAIL basic_rd: got %0d required 1", rd_addr_reg_out); end
    n_cmp++; if (csr_addr_reg_out !== 12'd2) begin n_err++; $display("FAIL basic_csr: got %0d required 2", csr_addr_reg_out); end
    n_cmp++; if (rs1_reg_out !== 32'd3) begin n_err++; $display("FAIL basic_rs1: got %0d required 3", rs1_reg_out); end
    n_cmp++; if (rs2_reg_out !== 32'd4) begin n_err++; $display("FAIL basic_rs2: got %0d required 4", rs2_reg_out); end
    n_cmp++; if (pc_reg_out !== 32'd5) begin n_err++; $display("FAIL basic_pc: got %0d required 5", pc_reg_out); end
    n_cmp++; if (pc_plus_reg_out !== 32'd6) begin n_err++; $display("FAIL basic_pc4: got %0d required 6", pc_plus_reg_out); end
    n_cmp++; if (alu_opcode_reg_out !== 4'd7) begin n_err++; $display("FAIL basic_aluop: got %0d required 7", alu_opcode_reg_out); end
    n_cmp++; if (imm_reg_out !== 32'd15) begin n_err++; $display("FAIL basic_imm: got %0d required 15", imm_reg_out); end
    n_cmp++; if (iadder_out_reg_out !== 32'd16) begin n_err++; $display("FAIL basic_iadder: got %0d required 16", iadder_out_reg_out); end
  endtask

  // The branch flag clears only bit 0 of the target and leaves every other field alone.
  task automatic test_iadder_lsb();
    @(negedge clk_in);
    iadder_out_in = 32'h21; branch_taken_in = 1'b1; rs1_in = 32'hA5; rf_wr_en_in = 1'b1;
    tick();
    n_cmp++; if (iadder_out_reg_out !== 32'h20) begin n_err++; $display("FAIL lsb_taken: got %h required 00000020", iadder_out_reg_out); end
    n_cmp++; if (rs1_reg_out !== 32'hA5) begin n_err++; $display("FAIL lsb_no_flush_rs1: got %h required 000000a5", rs1_reg_out); end
    n_cmp++; if (rf_wr_en_reg_out !== 1'b1) begin n_err++; $display("FAIL lsb_no_flush_we: got %b required 1", rf_wr_en_reg_out); end
    @(negedge clk_in);
    branch_taken_in = 1'b0;
    tick();
    n_cmp++; if (iadder_out_reg_out !== 32'h21) begin n_err++; $display("FAIL lsb_not_taken: got %h required 00000021", iadder_out_reg_out); end
  endtask

  task automatic test_mid_cycle();
    @(negedge clk_in);
    rs1_in = 32'd3;
    tick();
    #2 rs1_in = 32'h13;
    @(negedge clk_in);
    n_cmp++; if (rs1_reg_out !== 32'd3) begin n_err++; $display("FAIL midcycle_hold: got %h required 00000003", rs1_reg_out); end
    tick();
    n_cmp++; if (rs1_reg_out !== 32'h13) begin n_err++; $display("FAIL midcycle_load: got %h required 00000013", rs1_reg_out); end
  endtask

  // Reset asserted between edges clears everything at once; the first edge after release reloads.
  task automatic test_async_reset();
    @(negedge clk_in);
    rd_addr_in = 5'd17; pc_in = 32'h1000; imm_in = 32'h77; csr_op_in = 3'd5;
    tick();
    n_cmp++; if (pc_reg_out !== 32'h1000) begin n_err++; $display("FAIL arst_preload: got %h required 00001000", pc_reg_out); end
    #2 reset_in = 1'b1;
    #1;
    n_cmp++; if (all_outs !== '0) begin n_err++; $display("FAIL arst_clear: got %h required 0", all_outs); end
    @(negedge clk_in);
    reset_in = 1'b0;
    pc_in = 32'h2004; iadder_out_in = 32'h333; branch_taken_in = 1'b1;
    #1;
    n_cmp++; if (all_outs !== '0) begin n_err++; $display("FAIL arst_release_noedge: got %h required 0", all_outs); end
    tick();
    n_cmp++; if (pc_reg_out !== 32'h2004) begin n_err++; $display("FAIL arst_reload_pc: got %h required 00002004", pc_reg_out); end
    n_cmp++; if (iadder_out_reg_out !== 32'h332) begin n_err++; $display("FAIL arst_reload_iadder: got %h required 00000332", iadder_out_reg_out); end
    n_cmp++; if (rd_addr_reg_out !== 5'd17) begin n_err++; $display("FAIL arst_reload_rd: got %0d required 17", rd_addr_reg_out); end
  endtask

  task automatic test_max_values();
    @(negedge clk_in);
    load_unsigned_in = 1'b1; alu_src_in = 1'b1; csr_wr_en_in = 1'b1; rf_wr_en_in = 1'b1;
    load_size_in = 2'd3; wb_mux_sel_in = 3'd7; csr_op_in = 3'd7; alu_opcode_in = 4'hF;
    rd_addr_in = 5'd31; csr_addr_in = 12'hFFF; branch_taken_in = 1'b0;
    rs1_in = '1; rs2_in = '1; pc_in = '1; pc_plus_4_in = '1; imm_in = '1; iadder_out_in = '1;
    tick();
    n_cmp++; if ({load_unsigned_reg_out, alu_src_reg_out, csr_wr_en_reg_out, rf_wr_en_reg_out} !== 4'hF) begin
      n_err++; $display("FAIL max_flags: got %b required 1111",
        {load_unsigned_reg_out, alu_src_reg_out, csr_wr_en_reg_out, rf_wr_en_reg_out});
    end
    n_cmp++; if (load_size_reg_out !== 2'd3) begin n_err++; $display("FAIL max_load_size: got %0d required 3", load_size_reg_out); end
    n_cmp++; if (wb_mux_sel_reg_out !== 3'd7) begin n_err++; $display("FAIL max_wb_sel: got %0d required 7", wb_mux_sel_reg_out); end
    n_cmp++; if (csr_op_reg_out !== 3'd7) begin n_err++; $display("FAIL max_csr_op: got %0d required 7", csr_op_reg_out); end
    n_cmp++; if ({rd_addr_reg_out, csr_addr_reg_out, alu_opcode_reg_out} !== 21'h1FFFFF) begin
      n_err++; $display("FAIL max_addr_op: got %h required 1fffff", {rd_addr_reg_out, csr_addr_reg_out, alu_opcode_reg_out});
    end
    n_cmp++; if ({rs1_reg_out, rs2_reg_out, pc_reg_out, pc_plus_reg_out, imm_reg_out, iadder_out_reg_out} !== {192{1'b1}}) begin
      n_err++; $display("FAIL max_words: got %h required all ones",
        {rs1_reg_out, rs2_reg_out, pc_reg_out, pc_plus_reg_out, imm_reg_out, iadder_out_reg_out});
    end
  endtask

  // One new vector every cycle; each must appear exactly one edge later.
  task automatic test_back_to_back();
    logic [31:0] vec_rs2 [4];
    logic [31:0] vec_iad [4];
    logic        vec_bt  [4];
    logic [31:0] exp_iad [4];
    vec_rs2[0] = 32'h1111_0000; vec_iad[0] = 32'h0000_0101; vec_bt[0] = 1'b1; exp_iad[0] = 32'h0000_0100;
    vec_rs2[1] = 32'h2222_0001; vec_iad[1] = 32'h0000_0203; vec_bt[1] = 1'b0; exp_iad[1] = 32'h0000_0203;
    vec_rs2[2] = 32'h3333_0002; vec_iad[2] = 32'hFFFF_FFFF; vec_bt[2] = 1'b1; exp_iad[2] = 32'hFFFF_FFFE;
    vec_rs2[3] = 32'h4444_0003; vec_iad[3] = 32'h8000_0000; vec_bt[3] = 1'b1; exp_iad[3] = 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      rs2_in = vec_rs2[i]; iadder_out_in = vec_iad[i]; branch_taken_in = vec_bt[i];
      tick();
      n_cmp++; if (rs2_reg_out !== vec_rs2[i]) begin n_err++; $display("FAIL b2b_rs2[%0d]: got %h required %h", i, rs2_reg_out, vec_rs2[i]); end
      n_cmp++; if (iadder_out_reg_out !== exp_iad[i]) begin n_err++; $display("FAIL b2b_iadder[%0d]: got %h required %h", i, iadder_out_reg_out, exp_iad[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_iadder_lsb();
    test_mid_cycle();
    test_async_reset();
    test_max_values();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
